// File: rtl/ins_trace_sched_if.sv
// Handshake bundle joining the decode/commit trace producers and the print sink
// to ins_trace_sched; the scheduler takes the slave side.
interface ins_trace_sched_if #(
    parameter int RECW  = 256,
    parameter int BEATW = 64
);
    logic             trace_en;
    logic             dec_valid;
    logic             dec_ready;
    logic [RECW-1:0]  dec_rec;
    logic             cmt_valid;
    logic             cmt_ready;
    logic [RECW-1:0]  cmt_rec;
    logic             out_valid;
    logic             out_ready;
    logic [BEATW-1:0] out_data;
    logic             out_first;
    logic             out_last;
    logic             out_src;
    logic [15:0]      out_seq;

    modport slave (
        input  trace_en, dec_valid, dec_rec, cmt_valid, cmt_rec, out_ready,
        output dec_ready, cmt_ready, out_valid, out_data, out_first, out_last,
               out_src, out_seq
    );

    modport master (
        output trace_en, dec_valid, dec_rec, cmt_valid, cmt_rec, out_ready,
        input  dec_ready, cmt_ready, out_valid, out_data, out_first, out_last,
               out_src, out_seq
    );
endinterface

// File: rtl/ins_trace_sched.sv
// Trace-output scheduler: per-source record FIFOs, round-robin arbitration and
// MSB-first serialisation of each record into BEATW-wide beats with source/seq tags.
module ins_trace_sched #(
    parameter int RECW       = 256,
    parameter int BEATW      = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    ins_trace_sched_if.slave bus
);
    localparam int BEATS = RECW / BEATW;
    localparam int CNTW  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTRW  = $clog2(FIFO_DEPTH);
    localparam int LVLW  = $clog2(FIFO_DEPTH + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(BEATS - 1);
    localparam logic [LVLW-1:0] FULL_LVL  = LVLW'(FIFO_DEPTH);

    logic [RECW-1:0]  mem_q [2][FIFO_DEPTH];
    logic [RECW-1:0]  mem_d [2][FIFO_DEPTH];
    logic [PTRW-1:0]  wr_ptr_q [2];
    logic [PTRW-1:0]  wr_ptr_d [2];
    logic [PTRW-1:0]  rd_ptr_q [2];
    logic [PTRW-1:0]  rd_ptr_d [2];
    logic [LVLW-1:0]  level_q [2];
    logic [LVLW-1:0]  level_d [2];

    logic [0:0]       state_q, state_d;
    logic             grant_q, grant_d;
    logic             prio_q, prio_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [15:0]      seq_q, seq_d;

    logic [1:0]       full;
    logic [1:0]       nonempty;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic             send;
    logic             last_acc;
    logic [RECW-1:0]  head;
    logic [BEATW-1:0] beat;

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            full[s]     = (level_q[s] == FULL_LVL);
            nonempty[s] = (level_q[s] != '0);
        end
        push     = {bus.cmt_valid, bus.dec_valid} & ~full & {2{bus.trace_en}};
        send     = (state_q == ST_SEND);
        last_acc = send && bus.out_ready && (cnt_q == LAST_BEAT);
        pop      = {last_acc && grant_q, last_acc && !grant_q};
    end

    // Ready depends only on stored occupancy; a pop in the same cycle never frees a full FIFO early.
    assign bus.dec_ready = !bus.trace_en || !full[0];
    assign bus.cmt_ready = !bus.trace_en || !full[1];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
                mem_d[s][wr_ptr_q[s]] = (s == 0) ? bus.dec_rec : bus.cmt_rec;
                wr_ptr_d[s]           = wr_ptr_q[s] + PTRW'(1);
            end
            if (pop[s]) begin
                rd_ptr_d[s] = rd_ptr_q[s] + PTRW'(1);
            end
            case ({push[s], pop[s]})
                2'b10:   level_d[s] = level_q[s] + LVLW'(1);
                2'b01:   level_d[s] = level_q[s] - LVLW'(1);
                default: level_d[s] = level_q[s];
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        seq_d   = seq_q;
        case (state_q)
            ST_IDLE: begin
                if (|nonempty) begin
                    state_d = ST_SEND;
                    cnt_d   = '0;
                    grant_d = (&nonempty) ? prio_q : nonempty[1];
                end
            end
            default: begin
                if (bus.out_ready) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        seq_d   = seq_q + 16'd1;
                        prio_d  = ~grant_q;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
            end
        endcase
    end

    // Record storage carries no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < 2; s++) begin
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
                level_q[s]  <= '0;
            end
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
            seq_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            state_q  <= state_d;
            grant_q  <= grant_d;
            prio_q   <= prio_d;
            cnt_q    <= cnt_d;
            seq_q    <= seq_d;
        end
    end

    always_comb begin
        head = mem_q[grant_q][rd_ptr_q[grant_q]];
        beat = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (cnt_q == CNTW'(k)) begin
                beat = head[RECW-1-BEATW*k -: BEATW];
            end
        end
    end

    // Every sink-facing output is forced to zero outside SEND so reset and idle look identical.
    assign bus.out_valid = send;
    assign bus.out_first = send && (cnt_q == '0);
    assign bus.out_last  = send && (cnt_q == LAST_BEAT);
    assign bus.out_src   = send && grant_q;
    assign bus.out_seq   = send ? seq_q : 16'h0000;
    assign bus.out_data  = send ? beat : '0;
endmodule

// File: tb/tb_ins_trace_sched.sv
// Self-checking bench for ins_trace_sched: vector table plus hand sequences,
// with a beat scoreboard that also checks stability under backpressure.
module tb_ins_trace_sched;
    localparam int RECW       = 256;
    localparam int BEATW      = 64;
    localparam int BEATS      = RECW / BEATW;
    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic [BEATW-1:0] data;
        logic             first;
        logic             last;
        logic             src;
        logic [15:0]      seq;
    } beat_t;

    typedef struct {
        logic            src;
        logic            en;
        logic [RECW-1:0] rec;
        logic            emit;
        logic [15:0]     seq;
    } vec_t;

    logic  clk = 1'b0;
    logic  reset_n;
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;
    beat_t exp_q[$];
    vec_t  vecs[7];

    ins_trace_sched_if #(.RECW(RECW), .BEATW(BEATW)) bus();

    ins_trace_sched #(.RECW(RECW), .BEATW(BEATW), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [RECW-1:0] randRec();
        logic [RECW-1:0] r;
        for (int i = 0; i < RECW / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic expectRec(input logic src, input logic [15:0] seq, input logic [RECW-1:0] rec);
        logic [RECW-1:0] r;
        r = rec;
        for (int k = 0; k < BEATS; k++) begin
            exp_q.push_back({r[RECW-1 -: BEATW], (k == 0), (k == BEATS - 1), src, seq});
            r = r << BEATW;
        end
    endtask

    // Offer one record and hold it until the source is ready, then transfer it on the next edge.
    task automatic applyStimulus(input logic src, input logic [RECW-1:0] rec);
        int n;
        logic rdy;
        if (src) begin
            bus.cmt_valid = 1'b1;
            bus.cmt_rec   = rec;
        end else begin
            bus.dec_valid = 1'b1;
            bus.dec_rec   = rec;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            rdy = src ? bus.cmt_ready : bus.dec_ready;
        end while (!rdy && n < 40);
        checkOutput("push_ready", {63'd0, rdy}, 64'd1);
        @(posedge clk);
        #1;
        bus.dec_valid = 1'b0;
        bus.cmt_valid = 1'b0;
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n;
        n = 0;
        repeat (BEATS + 3) @(posedge clk);
        #1;
        while ((exp_q.size() != 0 || bus.out_valid) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic doReset();
        mon_en  = 1'b0;
        reset_n = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;
    endtask

    // Scoreboard monitor: pops on each accepted beat and checks held beats never change.
    initial begin
        beat_t cur, prev, e;
        bit    prev_stall;
        prev_stall = 1'b0;
        prev       = '0;
        forever begin
            @(negedge clk);
            cur = {bus.out_data, bus.out_first, bus.out_last, bus.out_src, bus.out_seq};
            if (!mon_en || !reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (cur !== prev) begin
                        errors++;
                        $display("[TB] FAIL stall_hold: got %h, required %h", cur, prev);
                    end
                end
                if (bus.out_valid && bus.out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_beat: got %h, required no beat", cur);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e) begin
                            errors++;
                            $display("[TB] FAIL beat: got %h, required %h", cur, e);
                        end
                    end
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev       = cur;
            end
        end
    end

    initial begin
        logic [RECW-1:0] rec1, r;
        logic [RECW-1:0] recs[10];
        logic [5:0]      vld_pat;

        bus.trace_en  = 1'b1;
        bus.dec_valid = 1'b0;
        bus.cmt_valid = 1'b0;
        bus.dec_rec   = '0;
        bus.cmt_rec   = '0;
        bus.out_ready = 1'b1;
        reset_n       = 1'b1;
        #1;
        reset_n = 1'b0;
        #2;
        checkOutput("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        checkOutput("rst_out_first", {63'd0, bus.out_first}, 64'd0);
        checkOutput("rst_out_last",  {63'd0, bus.out_last},  64'd0);
        checkOutput("rst_out_data",  bus.out_data,           64'd0);
        checkOutput("rst_dec_ready", {63'd0, bus.dec_ready}, 64'd1);
        checkOutput("rst_cmt_ready", {63'd0, bus.cmt_ready}, 64'd1);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Single record: latency and back-to-back beat pattern.
        rec1 = 256'h0123456789ABCDEF_FEDCBA9876543210_0011223344556677_8899AABB89ABCDEF;
        expectRec(1'b0, 16'h0000, rec1);
        bus.dec_valid = 1'b1;
        bus.dec_rec   = rec1;
        @(posedge clk);
        #1;
        bus.dec_valid = 1'b0;
        vld_pat = 6'b011110;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput($sformatf("latency_valid_%0d", i), {63'd0, bus.out_valid}, {63'd0, vld_pat[i]});
            if (i == 1) checkOutput("first_beat_data", bus.out_data, 64'h0123456789ABCDEF);
        end
        @(posedge clk);
        #1;
        waitDrain("drain_single", 40);

        // Vector table: trace_en gating and per-source sequencing from a fresh reset.
        doReset();
        vecs[0] = '{1'b1, 1'b0, randRec(), 1'b0, 16'h0000};
        vecs[1] = '{1'b1, 1'b0, randRec(), 1'b0, 16'h0000};
        vecs[2] = '{1'b1, 1'b1, randRec(), 1'b1, 16'h0000};
        vecs[3] = '{1'b0, 1'b1, randRec(), 1'b1, 16'h0001};
        vecs[4] = '{1'b1, 1'b1, randRec(), 1'b1, 16'h0002};
        vecs[5] = '{1'b0, 1'b0, randRec(), 1'b0, 16'h0000};
        vecs[6] = '{1'b0, 1'b1, randRec(), 1'b1, 16'h0003};
        for (int v = 0; v < 7; v++) begin
            bus.trace_en = vecs[v].en;
            if (vecs[v].emit) expectRec(vecs[v].src, vecs[v].seq, vecs[v].rec);
            applyStimulus(vecs[v].src, vecs[v].rec);
            bus.trace_en = 1'b1;
            waitDrain($sformatf("drain_vec_%0d", v), 40);
        end

        // Both sources push together: round-robin interleave starting with decode.
        doReset();
        for (int i = 0; i < 6; i++) recs[i] = randRec();
        for (int i = 0; i < 3; i++) begin
            expectRec(1'b0, 16'(2 * i), recs[2*i]);
            expectRec(1'b1, 16'(2 * i + 1), recs[2*i+1]);
        end
        for (int i = 0; i < 3; i++) begin
            bus.dec_valid = 1'b1;
            bus.dec_rec   = recs[2*i];
            bus.cmt_valid = 1'b1;
            bus.cmt_rec   = recs[2*i+1];
            @(negedge clk);
            checkOutput("rr_dec_ready", {63'd0, bus.dec_ready}, 64'd1);
            checkOutput("rr_cmt_ready", {63'd0, bus.cmt_ready}, 64'd1);
            @(posedge clk);
            #1;
        end
        bus.dec_valid = 1'b0;
        bus.cmt_valid = 1'b0;
        waitDrain("drain_rr", 100);

        // Backpressure: fill decode FIFO, hold a fifth record off, then release.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            recs[i] = randRec();
            expectRec(1'b0, 16'(6 + i), recs[i]);
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, recs[i]);
        bus.dec_valid = 1'b1;
        bus.dec_rec   = recs[4];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("bp_dec_ready_full", {63'd0, bus.dec_ready}, 64'd0);
            checkOutput("bp_held_first", {63'd0, bus.out_first}, 64'd1);
        end
        bus.trace_en = 1'b0;
        #1;
        checkOutput("bp_ready_trace_off", {63'd0, bus.dec_ready}, 64'd1);
        bus.trace_en = 1'b1;
        #1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        applyStimulus(1'b0, recs[4]);
        waitDrain("drain_bp", 200);

        // Sequence counter wrap from 0xFFFF.
        force dut.seq_q = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        release dut.seq_q;
        recs[0] = randRec();
        recs[1] = randRec();
        expectRec(1'b0, 16'hFFFF, recs[0]);
        expectRec(1'b1, 16'h0000, recs[1]);
        applyStimulus(1'b0, recs[0]);
        applyStimulus(1'b1, recs[1]);
        waitDrain("drain_wrap", 60);

        // Reset during the second beat of a record with another record queued.
        r = randRec();
        expectRec(1'b0, 16'h0001, r);
        applyStimulus(1'b0, r);
        applyStimulus(1'b1, randRec());
        @(posedge clk);
        #1;
        checkOutput("mid_second_beat", bus.out_data, r[RECW-1-BEATW -: BEATW]);
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        checkOutput("midrst_out_last",  {63'd0, bus.out_last},  64'd0);
        checkOutput("midrst_out_src",   {63'd0, bus.out_src},   64'd0);
        checkOutput("midrst_out_seq",   {48'd0, bus.out_seq},   64'd0);
        checkOutput("midrst_out_data",  bus.out_data,           64'd0);
        checkOutput("midrst_cmt_ready", {63'd0, bus.cmt_ready}, 64'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;
        waitDrain("post_reset_empty", 10);
        r = randRec();
        expectRec(1'b0, 16'h0000, r);
        applyStimulus(1'b0, r);
        waitDrain("drain_post_reset", 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
